// File: rtl/motor_ctrl_multicanal.sv
// motor_ctrl_multicanal
//   Per-channel corking-line conveyor motor controller. Each of N_CANAIS
//   channels runs an independent Moore FSM:
//     IDLE -> RUN -> SETTLE -> HOLD -> IDLE, plus RUN -> FAULT on a jam.
//   After a bottle is sensed the motor runs ATRASO_PARADA more cycles, which
//   centres the bottle under the corker. A RUN phase with no bottle for
//   TIMEOUT_JAM cycles latches a fault that only LIMPA_FALHA clears.
//   A saturating counter totals the bottles that reach HOLD.
//
// Ports
//   CLOCK               in   system clock, rising edge
//   RESET               in   asynchronous, active-high reset
//   START               in   [N_CANAIS] per-channel run enable (level)
//   ROLHAS_DISPONIVEIS  in   [N_CANAIS] corks available in channel feeder
//   GARRAFA_PRESENTE    in   [N_CANAIS] bottle sensor at corking station
//   LIMPA_FALHA         in   [N_CANAIS] fault clear (sampled level)
//   MOTOR_ATIVO         out  [N_CANAIS] motor drive (RUN or SETTLE)
//   PRONTO              out  [N_CANAIS] bottle positioned, ready to cork
//   FALHA               out  [N_CANAIS] latched jam fault
//   FALHA_GLOBAL        out  OR of FALHA
//   GARRAFAS_TOTAL      out  [W_CONT] bottles positioned since reset
module motor_ctrl_multicanal #(
    parameter int N_CANAIS      = 4,
    parameter int ATRASO_PARADA = 4,
    parameter int TIMEOUT_JAM   = 20,
    parameter int W_TEMPO       = 8,
    parameter int W_CONT        = 16
) (
    input  logic                CLOCK,
    input  logic                RESET,
    input  logic [N_CANAIS-1:0] START,
    input  logic [N_CANAIS-1:0] ROLHAS_DISPONIVEIS,
    input  logic [N_CANAIS-1:0] GARRAFA_PRESENTE,
    input  logic [N_CANAIS-1:0] LIMPA_FALHA,
    output logic [N_CANAIS-1:0] MOTOR_ATIVO,
    output logic [N_CANAIS-1:0] PRONTO,
    output logic [N_CANAIS-1:0] FALHA,
    output logic                FALHA_GLOBAL,
    output logic [W_CONT-1:0]   GARRAFAS_TOTAL
);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        SETTLE,
        HOLD,
        FAULT
    } estado_t;

    localparam logic [W_TEMPO-1:0] FIM_JAM    = W_TEMPO'(TIMEOUT_JAM - 1);
    localparam logic [W_TEMPO-1:0] FIM_SETTLE = W_TEMPO'(ATRASO_PARADA - 1);

    // Sum is wide enough for total + N_CANAIS without overflow, so the
    // saturation test is a plain compare.
    localparam int W_SOMA = W_CONT + $clog2(N_CANAIS + 1);
    localparam logic [W_SOMA-1:0] SOMA_MAX = {{(W_SOMA - W_CONT){1'b0}}, {W_CONT{1'b1}}};

    estado_t            estado_q [N_CANAIS];
    estado_t            estado_d [N_CANAIS];
    logic [W_TEMPO-1:0] tempo_q  [N_CANAIS];
    logic [W_TEMPO-1:0] tempo_d  [N_CANAIS];
    logic [W_CONT-1:0]  total_q;
    logic [W_CONT-1:0]  total_d;
    logic [W_SOMA-1:0]  n_entradas;
    logic [W_SOMA-1:0]  soma;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            for (int unsigned i = 0; i < N_CANAIS; i++) begin
                estado_q[i] <= IDLE;
                tempo_q[i]  <= '0;
            end
            total_q <= '0;
        end else begin
            for (int unsigned i = 0; i < N_CANAIS; i++) begin
                estado_q[i] <= estado_d[i];
                tempo_q[i]  <= tempo_d[i];
            end
            total_q <= total_d;
        end
    end

    always_comb begin
        n_entradas = '0;
        for (int unsigned i = 0; i < N_CANAIS; i++) begin
            estado_d[i] = estado_q[i];
            tempo_d[i]  = tempo_q[i];
            case (estado_q[i])
                IDLE: begin
                    tempo_d[i] = '0;
                    if (START[i] && ROLHAS_DISPONIVEIS[i] && !GARRAFA_PRESENTE[i])
                        estado_d[i] = RUN;
                end
                RUN: begin
                    if (!START[i] || !ROLHAS_DISPONIVEIS[i]) begin
                        estado_d[i] = IDLE;
                        tempo_d[i]  = '0;
                    end else if (GARRAFA_PRESENTE[i]) begin
                        estado_d[i] = SETTLE;
                        tempo_d[i]  = '0;
                    end else if (tempo_q[i] == FIM_JAM) begin
                        estado_d[i] = FAULT;
                        tempo_d[i]  = '0;
                    end else begin
                        tempo_d[i] = tempo_q[i] + W_TEMPO'(1);
                    end
                end
                SETTLE: begin
                    if (!START[i]) begin
                        estado_d[i] = IDLE;
                        tempo_d[i]  = '0;
                    end else if (tempo_q[i] == FIM_SETTLE) begin
                        estado_d[i] = HOLD;
                        tempo_d[i]  = '0;
                        n_entradas  = n_entradas + W_SOMA'(1);
                    end else begin
                        tempo_d[i] = tempo_q[i] + W_TEMPO'(1);
                    end
                end
                HOLD: begin
                    tempo_d[i] = '0;
                    if (!GARRAFA_PRESENTE[i])
                        estado_d[i] = IDLE;
                end
                FAULT: begin
                    tempo_d[i] = '0;
                    if (LIMPA_FALHA[i])
                        estado_d[i] = IDLE;
                end
                default: begin
                    estado_d[i] = IDLE;
                    tempo_d[i]  = '0;
                end
            endcase
        end

        soma = {{(W_SOMA - W_CONT){1'b0}}, total_q} + n_entradas;
        if (soma > SOMA_MAX)
            total_d = '1;
        else
            total_d = soma[W_CONT-1:0];
    end

    // Moore outputs: decoded from registered state only.
    always_comb begin
        MOTOR_ATIVO = '0;
        PRONTO      = '0;
        FALHA       = '0;
        for (int unsigned i = 0; i < N_CANAIS; i++) begin
            MOTOR_ATIVO[i] = (estado_q[i] == RUN) || (estado_q[i] == SETTLE);
            PRONTO[i]      = (estado_q[i] == HOLD);
            FALHA[i]       = (estado_q[i] == FAULT);
        end
        FALHA_GLOBAL   = |FALHA;
        GARRAFAS_TOTAL = total_q;
    end

endmodule

// File: doc/motor_ctrl_multicanal.md
Name: motor_ctrl_multicanal

Overview:
- Per-channel corking-line conveyor motor controller. Successor to the single-channel on/off motor FSM.
- N_CANAIS independent channels, each running a 5-state Moore FSM.
- Adds three behaviours the single-channel FSM lacks: a post-detection settle delay that centres the bottle under the corker, a jam timeout with a latched fault and explicit clear, and a saturating delivered-bottle counter.
- Sits between the line operator inputs/sensors and the motor drivers and corker sequencer.

Parameters:
- N_CANAIS, 4, number of independent conveyor channels (≥1).
- ATRASO_PARADA, 4, cycles the motor keeps running after a bottle is sensed (≥1).
- TIMEOUT_JAM, 20, maximum cycles in RUN without a bottle before fault (≥2).
- W_TEMPO, 8, per-channel timer width; must satisfy 2^W_TEMPO > max(ATRASO_PARADA, TIMEOUT_JAM).
- W_CONT, 16, width of the delivered-bottle counter.

Ports:
- CLOCK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- START  in  N_CANAIS  per-channel run enable (level).
- ROLHAS_DISPONIVEIS  in  N_CANAIS  corks available in channel feeder.
- GARRAFA_PRESENTE  in  N_CANAIS  bottle sensor at corking station.
- LIMPA_FALHA  in  N_CANAIS  fault clear (sampled level; a one-cycle pulse suffices).
- MOTOR_ATIVO  out  N_CANAIS  motor drive.
- PRONTO  out  N_CANAIS  bottle positioned, motor stopped, ready to cork.
- FALHA  out  N_CANAIS  latched jam fault.
- FALHA_GLOBAL  out  1  OR of FALHA.
- GARRAFAS_TOTAL  out  W_CONT  bottles positioned since reset.

Behaviour:
- Reset (async, RESET=1): all channels IDLE, timers 0, GARRAFAS_TOTAL=0.
  - All outputs 0 while RESET is high and in the first cycle after release.
  - Reset mid-operation aborts any state immediately, including FAULT, which is cleared.
- Moore FSM per channel i, one transition per rising edge. Outputs decode the registered state, so inputs affect outputs one cycle later.
- IDLE (motor off):
  - Go to RUN if START & ROLHAS_DISPONIVEIS & !GARRAFA_PRESENTE; timer cleared.
  - Otherwise stay in IDLE.
- RUN (MOTOR_ATIVO=1, timer +1 per cycle). Priority:
  1. !START or !ROLHAS_DISPONIVEIS -> IDLE.
  2. GARRAFA_PRESENTE -> SETTLE, timer cleared.
  3. Timer == TIMEOUT_JAM-1 -> FAULT.
  4. Otherwise stay in RUN.
  - Consequence: a jam yields exactly TIMEOUT_JAM cycles of MOTOR_ATIVO=1.
- SETTLE (MOTOR_ATIVO=1, timer +1 per cycle):
  - !START -> IDLE.
  - Else if timer == ATRASO_PARADA-1 -> HOLD.
  - GARRAFA_PRESENTE and ROLHAS_DISPONIVEIS are ignored. MOTOR_ATIVO stays high exactly ATRASO_PARADA cycles.
- HOLD (PRONTO=1, motor off):
  - !GARRAFA_PRESENTE -> IDLE; restart requires a further cycle through IDLE.
  - START is ignored.
- FAULT (FALHA=1, motor off):
  - Exit only on LIMPA_FALHA -> IDLE.
  - LIMPA_FALHA in any other state has no effect.
- FALHA_GLOBAL is the registered-state OR, with the same timing as FALHA.
- GARRAFAS_TOTAL:
  - Adds the count of channels transitioning SETTLE->HOLD on the current edge. Simultaneous entries are all counted (0..N_CANAIS per cycle).
  - Saturates at 2^W_CONT-1; never wraps.
- Channels are fully independent; no shared arbitration.
- Timer never exceeds its terminal value; no wrap possible.

Test Plan (N_CANAIS=4, ATRASO_PARADA=4, TIMEOUT_JAM=20):
- Normal cycle, ch0:
  - START=ROLHAS=1, GARRAFA=0 at edge k -> MOTOR_ATIVO[0]=1 from k+1.
  - GARRAFA=1 sampled at edge m -> motor stays high through 4 SETTLE cycles, low from m+5 with PRONTO[0]=1, GARRAFAS_TOTAL=1.
  - GARRAFA=0 -> PRONTO[0]=0 next cycle.
- Jam, ch1:
  - START=ROLHAS=1, no bottle -> MOTOR_ATIVO[1] high exactly 20 cycles, then FALHA[1]=FALHA_GLOBAL=1 and motor 0.
  - START toggling leaves the fault held.
  - LIMPA_FALHA[1] pulse -> FALHA[1]=0 next cycle, then restart.
- Abort: ROLHAS[2] drops during RUN -> motor off next cycle, IDLE, no count.
  - START[2] drops during SETTLE cycle 2 -> IDLE, PRONTO never asserted, count unchanged.
- Simultaneous: all 4 channels enter HOLD on the same edge -> GARRAFAS_TOTAL increments by 4 in one cycle.
  - With W_CONT=3 preloaded to 6 by sequence: +4 -> saturates at 7.
- Reset: RESET asserted mid-SETTLE on ch0 and in FAULT on ch1 -> all outputs 0 immediately (async), counter 0.
  - After release, no motor until START is re-evaluated in IDLE.
- Start blocked by bottle: START=ROLHAS=1 with GARRAFA=1 from IDLE -> motor stays 0 indefinitely.
